// File: rtl/inst_packer_pkg.sv
// Shared definitions for the MIPS instruction packer: format codes, field bit ranges, states.
// The optional legality check in inst_packer is enabled by defining INST_PACKER_CHECK_EN.
package inst_packer_pkg;

  localparam int unsigned WORD_W   = 32;

  localparam int unsigned OP_HI    = 31;
  localparam int unsigned OP_LO    = 26;
  localparam int unsigned RS_HI    = 25;
  localparam int unsigned RS_LO    = 21;
  localparam int unsigned RT_HI    = 20;
  localparam int unsigned RT_LO    = 16;
  localparam int unsigned RD_HI    = 15;
  localparam int unsigned RD_LO    = 11;
  localparam int unsigned SH_HI    = 10;
  localparam int unsigned SH_LO    = 6;
  localparam int unsigned FUNCT_HI = 5;
  localparam int unsigned FUNCT_LO = 0;
  localparam int unsigned IMM_HI   = 15;
  localparam int unsigned IMM_LO   = 0;
  localparam int unsigned JIDX_HI  = 25;
  localparam int unsigned JIDX_LO  = 0;

  typedef enum logic [1:0] {
    FMT_R   = 2'd0,
    FMT_I   = 2'd1,
    FMT_J   = 2'd2,
    FMT_RSV = 2'd3
  } fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } state_e;

  // Raw field tuple handed from the packer to the encoder
  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] j_index;
  } fields_t;

endpackage

// File: rtl/inst_packer_encode.sv
// Combinational encoder: format code plus field tuple to a 32-bit MIPS word.
// Reserved format falls back to the R layout.
module inst_encode
  import inst_packer_pkg::*;
(
  input  logic [1:0]        fmt_i,
  input  fields_t           fields_i,
  output logic [WORD_W-1:0] word_c
);

  always_comb begin
    word_c                  = '0;
    word_c[OP_HI:OP_LO]     = fields_i.op;
    case (fmt_i)
      FMT_I: begin
        word_c[RS_HI:RS_LO]   = fields_i.rs;
        word_c[RT_HI:RT_LO]   = fields_i.rt;
        word_c[IMM_HI:IMM_LO] = fields_i.imm;
      end
      FMT_J: begin
        word_c[JIDX_HI:JIDX_LO] = fields_i.j_index;
      end
      default: begin
        word_c[RS_HI:RS_LO]       = fields_i.rs;
        word_c[RT_HI:RT_LO]       = fields_i.rt;
        word_c[RD_HI:RD_LO]       = fields_i.rd;
        word_c[SH_HI:SH_LO]       = fields_i.shamt;
        word_c[FUNCT_HI:FUNCT_LO] = fields_i.funct;
      end
    endcase
  end

endmodule

// File: rtl/inst_packer.sv
// Packs field tuples into MIPS words and writes them to instruction memory at auto-incrementing addresses.
// Define INST_PACKER_CHECK_EN to drop illegal tuples (fmt=3, or R with op!=0) and raise the sticky err flag.
module inst_packer
  import inst_packer_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_3000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [1:0]                    fmt,
  input  logic [5:0]                    op,
  input  logic [4:0]                    rs,
  input  logic [4:0]                    rt,
  input  logic [4:0]                    rd,
  input  logic [4:0]                    shamt,
  input  logic [5:0]                    funct,
  input  logic [15:0]                   imm,
  input  logic [25:0]                   j_index,
  output logic                          im_we,
  output logic [31:0]                   im_addr,
  output logic [31:0]                   im_wdata,
  output logic [$clog2(DEPTH_WORDS):0]  count,
  output logic                          full,
  output logic                          err
);

  localparam int unsigned CW = $clog2(DEPTH_WORDS) + 1;

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [31:0]       addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [CW-1:0]     count_q, count_d;
  logic              full_q, full_d;
  logic              err_q, err_d;

  fields_t           fields_c;
  logic [WORD_W-1:0] word_c;
  logic              accept_c;
  logic              illegal_c;
  logic              last_c;

  assign fields_c = {op, rs, rt, rd, shamt, funct, imm, j_index};

  inst_encode u_encode (
    .fmt_i    (fmt),
    .fields_i (fields_c),
    .word_c   (word_c)
  );

  // start forces in_ready low so a simultaneous tuple is never taken
  assign in_ready = (state_q == ST_RUN) && !start;
  assign accept_c = in_valid && in_ready;
  assign last_c   = (count_q == CW'(DEPTH_WORDS - 1));

`ifdef INST_PACKER_CHECK_EN
  assign illegal_c = (fmt == FMT_RSV) || ((fmt == FMT_R) && (op != 6'd0));
`else
  assign illegal_c = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    count_d = count_q;
    full_d  = full_q;
    err_d   = err_q;
    if (start) begin
      state_d = ST_RUN;
      addr_d  = BASE_ADDR;
      count_d = '0;
      full_d  = 1'b0;
      err_d   = 1'b0;
    end else if (accept_c) begin
      if (illegal_c) begin
        err_d = 1'b1;
      end else begin
        we_d    = 1'b1;
        wdata_d = word_c;
        addr_d  = BASE_ADDR + (32'(count_q) << 2);
        count_d = count_q + CW'(1);
        if (last_c) begin
          state_d = ST_FULL;
          full_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      full_q  <= full_d;
      err_q   <= err_d;
    end
  end

  assign im_we    = we_q;
  assign im_addr  = addr_q;
  assign im_wdata = wdata_q;
  assign count    = count_q;
  assign full     = full_q;
  assign err      = err_q;

endmodule

// File: tb/tb_inst_packer.sv
// Bench for inst_packer (DEPTH_WORDS=4): directed test-plan steps plus random tuples vs a reference model.
module tb_inst_packer;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  fmt = '0;
  logic [5:0]  op = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [5:0]  funct = '0;
  logic [15:0] imm = '0;
  logic [25:0] j_index = '0;
  logic        im_we;
  logic [31:0] im_addr, im_wdata;
  logic [2:0]  count;
  logic        full, err;

  always #5 clk = ~clk;

  inst_packer #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm(imm), .j_index(j_index), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .count(count), .full(full), .err(err)
  );

  int vecs = 0;
  int errs = 0;

  // Reference model: 0 idle, 1 run, 2 full
  int          m_state;
  int          m_count;
  logic [31:0] m_addr, m_wdata;
  bit          m_we, m_full, m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [1:0] f, input logic [5:0] o, input logic [4:0] a,
                                      input logic [4:0] b, input logic [4:0] c, input logic [4:0] sh,
                                      input logic [5:0] fu, input logic [15:0] im, input logic [25:0] j);
    if (f == 2'd1) return 32'(o) * 32'h0400_0000 + 32'(a) * 32'h0020_0000 + 32'(b) * 32'h0001_0000 + 32'(im);
    if (f == 2'd2) return 32'(o) * 32'h0400_0000 + 32'(j);
    return 32'(o) * 32'h0400_0000 + 32'(a) * 32'h0020_0000 + 32'(b) * 32'h0001_0000
         + 32'(c) * 32'h0000_0800 + 32'(sh) * 32'h0000_0040 + 32'(fu);
  endfunction

  function automatic bit is_illegal(input logic [1:0] f, input logic [5:0] o);
`ifdef INST_PACKER_CHECK_EN
    return (f == 2'd3) || (f == 2'd0 && o != 6'd0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_state = 0; m_count = 0; m_addr = BASE; m_wdata = '0;
    m_we = 1'b0; m_full = 1'b0; m_err = 1'b0;
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".im_we"},   32'(im_we),  32'(m_we));
    chk({tag, ".im_addr"}, im_addr,     m_addr);
    chk({tag, ".count"},   32'(count),  32'(m_count));
    chk({tag, ".full"},    32'(full),   32'(m_full));
    chk({tag, ".err"},     32'(err),    32'(m_err));
    if (m_we) chk({tag, ".im_wdata"}, im_wdata, m_wdata);
  endtask

  // One clock cycle: drive inputs, check in_ready, clock, advance model, check outputs
  task automatic step(input string tag, input bit s, input bit v, input logic [1:0] f, input logic [5:0] o,
                      input logic [4:0] a, input logic [4:0] b, input logic [4:0] c, input logic [4:0] sh,
                      input logic [5:0] fu, input logic [15:0] im, input logic [25:0] j);
    bit exp_rdy;
    start = s; in_valid = v; fmt = f; op = o; rs = a; rt = b; rd = c;
    shamt = sh; funct = fu; imm = im; j_index = j;
    #1;
    exp_rdy = (m_state == 1) && !s;
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
    @(posedge clk); #1;
    m_we = 1'b0;
    if (s) begin
      m_state = 1; m_count = 0; m_addr = BASE; m_full = 1'b0; m_err = 1'b0;
    end else if (exp_rdy && v) begin
      if (is_illegal(f, o)) begin
        m_err = 1'b1;
      end else begin
        m_we = 1'b1;
        m_wdata = enc(f, o, a, b, c, sh, fu, im, j);
        m_addr = BASE + 32'(4 * m_count);
        m_count++;
        if (m_count == DEPTH) begin
          m_state = 2; m_full = 1'b1;
        end
      end
    end
    check_outs(tag);
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset");
    chk("reset.im_wdata", im_wdata, 32'h0);
    reset = 1'b0;

    step("idle_valid", 0, 1, 2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'd0, 26'd0);
    step("start1", 1, 0, 2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);

    step("r_word", 0, 1, 2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'd0, 26'd0);
    chk("r_word.const_data", im_wdata, 32'h0022_1821);
    chk("r_word.const_addr", im_addr, 32'h0000_3000);
    chk("r_word.const_cnt", 32'(count), 32'd1);

    step("i_word", 0, 1, 2'd1, 6'h0D, 5'd0, 5'd1, 5'd0, 5'd0, 6'd0, 16'h1234, 26'd0);
    chk("i_word.const_data", im_wdata, 32'h3401_1234);
    chk("i_word.const_addr", im_addr, 32'h0000_3004);
    step("j_word", 0, 1, 2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h0000C03);
    chk("j_word.const_data", im_wdata, 32'h0800_0C03);
    chk("j_word.const_addr", im_addr, 32'h0000_3008);
    chk("j_word.const_we", 32'(im_we), 32'd1);

    step("fourth", 0, 1, 2'd0, 6'd0, 5'd7, 5'd8, 5'd9, 5'd4, 6'h20, 16'd0, 26'd0);
    chk("fourth.const_full", 32'(full), 32'd1);
    chk("fourth.const_addr", im_addr, 32'h0000_300C);
    step("in_full", 0, 1, 2'd0, 6'd0, 5'd1, 5'd1, 5'd1, 5'd0, 6'h21, 16'd0, 26'd0);
    chk("in_full.const_we", 32'(im_we), 32'd0);

    step("start_prio", 1, 1, 2'd0, 6'd0, 5'd5, 5'd5, 5'd5, 5'd0, 6'h21, 16'd0, 26'd0);
    chk("start_prio.const_we", 32'(im_we), 32'd0);
    step("after_start", 0, 1, 2'd1, 6'h08, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'hBEEF, 26'd0);
    chk("after_start.const_addr", im_addr, 32'h0000_3000);
    chk("after_start.const_full", 32'(full), 32'd0);

    // Async reset between edges in the middle of a burst
    step("burst", 0, 1, 2'd0, 6'd0, 5'd9, 5'd10, 5'd11, 5'd1, 6'h22, 16'd0, 26'd0);
    in_valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outs("async_rst");
    chk("async_rst.const_we", 32'(im_we), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b0;
    step("post_rst1", 0, 1, 2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'd0, 26'd0);
    step("post_rst2", 0, 1, 2'd2, 6'd3, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h123);

`ifdef INST_PACKER_CHECK_EN
    step("chk_start", 1, 0, 2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    step("chk_rsv", 0, 1, 2'd3, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'd0, 26'd0);
    chk("chk_rsv.const_err", 32'(err), 32'd1);
    step("chk_next", 0, 1, 2'd0, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21, 16'd0, 26'd0);
    chk("chk_next.const_addr", im_addr, 32'h0000_3000);
    step("chk_clear", 1, 0, 2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    chk("chk_clear.const_err", 32'(err), 32'd0);
`endif

    for (int i = 0; i < 400; i++) begin
      logic [1:0] rf;
      logic [5:0] ro;
      rf = 2'($urandom_range(0, 3));
      ro = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
      step("rand", ($urandom_range(0, 11) == 0), ($urandom_range(0, 3) != 0), rf, ro,
           5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
           16'($urandom), 26'($urandom));
    end
    idle("tail");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/inst_packer.md
Name: inst_packer

Overview:
- Assembles MIPS instruction words from separate field values (op, rs, rt, rd, shamt, funct, imm, j_index) in R, I or J format.
- Each assembled word is written into the instruction-memory write port at an auto-incrementing, word-aligned address.
- It is the encoder counterpart to the instruction field splitter, and is used as the program loader and by test benches to build images field by field.

Parameters:
- DEPTH_WORDS, 1024, maximum words written per load session; at 1024 the packer enters FULL.
- BASE_ADDR, 32'h0000_3000, byte address of the first word written after start.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse: clear the counter to BASE_ADDR and enter RUN.
- in_valid  input  1  field tuple is valid this cycle.
- in_ready  output  1  the packer accepts a tuple this cycle.
- fmt  input  2  format: 0=R, 1=I, 2=J, 3=reserved.
- op  input  6  opcode field.
- rs  input  5  rs field.
- rt  input  5  rt field.
- rd  input  5  rd field.
- shamt  input  5  shift-amount field.
- funct  input  6  funct field.
- imm  input  16  immediate field.
- j_index  input  26  jump index field.
- im_we  output  1  instruction-memory write enable.
- im_addr  output  32  byte address of the write.
- im_wdata  output  32  assembled instruction word.
- count  output  11  words written since the last start.
- full  output  1  DEPTH_WORDS words have been written.
- err  output  1  sticky error flag; constant 0 without the optional feature.

Behaviour:
- Reset (asynchronous, active-high, takes effect immediately):
  - state=IDLE, im_we=0, im_addr=BASE_ADDR, im_wdata=0, count=0, full=0, err=0.
- States:
  - IDLE: in_ready=0. start -> RUN.
  - RUN: in_ready=1. An accept (in_valid && in_ready) registers the word.
  - FULL: in_ready=0, full=1. Only start leaves FULL.
- Encoding:
  - R: {op,rs,rt,rd,shamt,funct}.
  - I: {op,rs,rt,imm}.
  - J: {op,j_index}.
  - fmt=3 without the optional feature: encoded as R.
- Latency and address sequence:
  - An accept in cycle N gives im_we=1 in cycle N+1, with im_wdata = the encoded word and im_addr = BASE_ADDR + 4*count_before.
  - count increments in cycle N+1. im_addr holds its value after the write.
  - Back-to-back accepts give im_we=1 every cycle with addresses +4 each cycle.
  - im_we=0 in any cycle not preceded by an accept.
- Full boundary:
  - The accept that makes count==DEPTH_WORDS moves the state to FULL in the same edge; full=1 in cycle N+1, concurrent with the last write.
  - in_valid in FULL is ignored; no write occurs.
- start:
  - start in any state: count=0, im_addr=BASE_ADDR, full=0, err=0, state=RUN.
  - start has priority over a simultaneous in_valid, which is not accepted because in_ready is forced 0 that cycle.
  - A pending write from the previous cycle still completes at its original address.
- Arithmetic: the address is 32-bit modulo 2^32 and no carry is detected. count width is clog2(DEPTH_WORDS)+1 bits; it is 11 at the default.
- Reset mid-session: the session is aborted; any in-flight im_we is cleared immediately.

Optional Feature:
- INST_PACKER_CHECK_EN defined:
  - Illegal tuples are fmt=3, or fmt=0 with op!=0.
  - An illegal tuple is still accepted (handshake unchanged) but produces no write and does not increment count.
  - It sets err=1 in cycle N+1; err stays set until start or reset.
- Not defined: err tied 0, fmt=3 encoded as R, and the op field is passed through unchanged.

Decomposition:
- Shared package/macro header holds:
  - format codes FMT_R/FMT_I/FMT_J/FMT_RSV;
  - the field bit ranges already used by the field splitter (OP 31:26, RS 25:21, RT 20:16, RD 15:11, S 10:6, FUNCT 5:0, IMM 15:0, J 25:0);
  - the word width;
  - the state encodings.
- One natural sub-module: inst_encode, purely combinational, turning fmt plus fields into a word. The FSM, counter and output registers stay in inst_packer.

Test Plan:
- Single R word: reset, start, then R tuple op=0 rs=1 rt=2 rd=3 shamt=0 funct=0x21 -> next cycle im_we=1, im_addr=0x3000, im_wdata=0x00221821, count=1.
- Back-to-back I then J: I op=0x0D rs=0 rt=1 imm=0x1234, then J op=2 j_index=0x0000C03 on consecutive cycles -> writes 0x34011234 @0x3004 and 0x08000C03 @0x3008 on consecutive cycles, im_we never dropping.
- Full boundary: DEPTH_WORDS=4, in_valid held high -> exactly 4 writes @0x3000..0x300C, full=1 with the 4th write, in_ready=0 afterwards, no 5th write.
- start priority: start and in_valid asserted together in FULL -> no write that cycle; count=0; next accepted tuple is written @0x3000 and full=0.
- Async reset mid-stream: assert reset between clock edges during a back-to-back burst -> im_we drops immediately, state IDLE, count=0; tuples are ignored until start.
- With INST_PACKER_CHECK_EN: fmt=3 tuple -> no im_we, err=1, count unchanged; a following valid R tuple writes to the next address; start clears err.
